// File: rtl/slc3_trace_buffer.sv
// ============================================================================
// Module  : slc3_trace_buffer
// Purpose : Circular register-trace capture for the SLC-3 datapath probes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module slc3_trace_buffer #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*WIDTH-1:0]    i_probe,
    input  logic                         i_sample_en,
    input  logic [1:0]                   i_mode,
    input  logic                         i_arm,
    input  logic                         i_trig,
    input  logic                         i_stop,
    input  logic                         i_rd_en,
    output logic [CHANNELS*WIDTH-1:0]    o_rd_data,
    output logic                         o_rd_valid,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_overflow,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = CHANNELS * WIDTH;

    localparam logic [CW-1:0] c_DEPTH       = CW'(DEPTH);
    localparam logic [CW-1:0] c_POST_TRIG   = CW'(POST_TRIG);
    localparam logic [1:0]    c_MODE_CHANGE = 2'b01;
    localparam logic [1:0]    c_MODE_TRIG   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_mode;
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count, r_post_cnt;
    logic            r_overflow;
    logic [DW-1:0]   r_last;
    logic            r_have_last;
    logic [DW-1:0]   r_rd_data;
    logic            r_rd_valid;
    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_qual, w_wr, w_rd, w_post_load;

    // On-change mode filters against the last word actually stored.
    assign w_qual = i_sample_en &&
                    ((r_mode != c_MODE_CHANGE) || !r_have_last || (i_probe != r_last));

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_rd        = 1'b0;
        w_post_load = 1'b0;
        if (i_arm) begin
            w_state_nxt = S_CAPTURE;
        end else begin
            case (r_state)
                S_CAPTURE: begin
                    w_wr = w_qual;
                    if (r_mode == c_MODE_TRIG) begin
                        if (i_trig) begin
                            if (c_POST_TRIG == '0) begin
                                w_wr        = 1'b0;
                                w_state_nxt = S_DONE;
                            end else begin
                                w_post_load = 1'b1;
                                w_state_nxt = (w_qual && c_POST_TRIG == CW'(1)) ? S_DONE : S_POST;
                            end
                        end
                    end else if (i_stop) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_POST: begin
                    w_wr = i_sample_en;
                    if (i_sample_en && r_post_cnt == CW'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    w_rd = i_rd_en && (r_count != '0);
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_probe;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'b00;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_post_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_last      <= '0;
            r_have_last <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_valid <= w_rd;
            if (i_arm) begin
                r_mode      <= i_mode;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_post_cnt  <= '0;
                r_overflow  <= 1'b0;
                r_have_last <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_wr_ptr    <= r_wr_ptr + AW'(1);
                    r_last      <= i_probe;
                    r_have_last <= 1'b1;
                    // A write into a full buffer drops the oldest entry.
                    if (r_count == c_DEPTH) begin
                        r_rd_ptr   <= r_rd_ptr + AW'(1);
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                if (w_post_load) begin
                    r_post_cnt <= w_wr ? (c_POST_TRIG - CW'(1)) : c_POST_TRIG;
                end else if (w_wr && r_state == S_POST) begin
                    r_post_cnt <= r_post_cnt - CW'(1);
                end
                if (w_rd) begin
                    r_rd_data <= r_mem[r_rd_ptr];
                    r_rd_ptr  <= r_rd_ptr + AW'(1);
                    r_count   <= r_count - CW'(1);
                end
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_count    = r_count;
    assign o_full     = (r_count == c_DEPTH);
    assign o_overflow = r_overflow;
    assign o_busy     = (r_state == S_CAPTURE) || (r_state == S_POST);
    assign o_done     = (r_state == S_DONE);

endmodule

`default_nettype wire
